decode_issue_stage: RTL and testbench
=====================================

DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameter XLEN, default 32, data and PC width.
REQ-002 Parameter NPORTS, default 2, number of register read ports.
REQ-003 Parameter NFWD, default 3, number of forwarding sources; index 0 is the youngest.
REQ-004 Parameter RID_W, default 5, register id width.
REQ-005 Parameter CNT_W, default 8, stall counter width.
REQ-006 clock  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  1  fetch result valid; in_pc  in  XLEN; in_instr  in  32.
REQ-009 in_rs_id  in  NPORTS*RID_W  source ids; in_rs_need  in  NPORTS  operand needed at this stage.
REQ-010 rf_data  in  NPORTS*XLEN  register file read data, per port.
REQ-011 in_wr_en  in  1  writes a register; in_rd_id  in  RID_W; in_wr_ready  in  1  write data known at decode; in_wr_data  in  XLEN.
REQ-012 fwd_id  in  NFWD*RID_W; fwd_ready  in  NFWD; fwd_data  in  NFWD*XLEN  results of younger stages.
REQ-013 downstream_stall  in  1  next stage cannot accept; flush  in  1  squash the instruction being issued.
REQ-014 out_valid  out  1; out_pc  out  XLEN; out_instr  out  32; out_rs_data  out  NPORTS*XLEN; out_rd_id  out  RID_W; out_wr_ready  out  1; out_wr_data  out  XLEN.
REQ-015 op_data  out  NPORTS*XLEN  combinational forwarded operands, for branch compare.
REQ-016 stall_out  out  1  holds fetch.
REQ-017 self_id  out  RID_W; self_ready  out  1; self_data  out  XLEN  forwarding record of this stage.
REQ-018 stall_count  out  CNT_W; stall_saturated  out  1.

Function
REQ-019 Per port p: rs_id==0 -> op_data=0, no hazard.
REQ-020 Otherwise the lowest index i with fwd_id[i]==rs_id wins: fwd_ready[i]=1 -> op_data=fwd_data[i]; fwd_ready[i]=0 -> hazard_p.
REQ-021 No match -> op_data=rf_data[p], no hazard.
REQ-022 local_stall = in_valid AND OR over p of (in_rs_need[p] AND hazard_p); port hazards with in_rs_need[p]=0 are ignored.
REQ-023 stall_out = local_stall OR downstream_stall; stall_out is not asserted by flush alone.
REQ-024 Priority at each edge: reset, then flush, then downstream_stall, then load.
REQ-025 flush=1: out_valid<=0 next cycle, regardless of downstream_stall.
REQ-026 downstream_stall=1 (no flush): all output registers hold.
REQ-027 Otherwise, if in_valid AND NOT local_stall: capture pc, instr, op_data, rd_id, wr_ready, wr_data and set out_valid<=1; else out_valid<=0 (bubble).
REQ-028 in_wr_en=0 at capture: out_rd_id<=0, out_wr_ready<=1, out_wr_data<=0.
REQ-029 Issue latency is one cycle from an accepted input to out_valid.
REQ-030 self_id/ready/data = out_rd_id/out_wr_ready/out_wr_data when out_valid, else 0/1/0.
REQ-031 stall_count increments each cycle local_stall=1 and saturates at 2^CNT_W-1.
REQ-032 stall_count clears to 0 on any cycle with local_stall=0 or flush=1.
REQ-033 stall_saturated = (stall_count == 2^CNT_W-1).
REQ-034 Simultaneous hazard and downstream_stall: the outputs hold and stall_count still counts.

Reset
REQ-035 reset=1: out_valid=0, out_rd_id=0, out_wr_ready=1, out_wr_data=0, stall_count=0.
REQ-036 Other datapath registers are undefined-but-unused after reset, and reset mid-stall discards the held instruction.

Verification
REQ-037 rs_id={3,4}, no fwd match, rf_data={0x11,0x22}, in_valid -> next cycle out_valid=1, out_rs_data={0x11,0x22}.
REQ-038 fwd_id[0]=3 ready data 0xA, fwd_id[2]=3 ready data 0xB -> port reading r3 gets 0xA.
REQ-039 fwd_id[1]=5 not ready, rs_need=1 -> stall_out=1, out_valid=0 next cycle, stall_count 1,2,3 over three cycles; when the match becomes ready -> issue, stall_count=0.
REQ-040 rs_id=0 while fwd_id[0]=0 ready data 0xFF -> op_data=0 with no stall.
REQ-041 CNT_W=2, hazard held 5 cycles -> stall_count 1,2,3,3,3 and stall_saturated=1 from cycle 3.
REQ-042 downstream_stall=1 with flush=1 -> out_valid=0 next cycle; downstream_stall=1 alone -> all outputs unchanged.

Source files
------------

// File: rtl/decode_issue_stage.sv
// -----------------------------------------------------------------------------
// decode_issue_stage
//   Decode/issue pipeline register with operand forwarding, a load-use hazard
//   stall and a saturating stall counter.
//
//   Ports
//     clock, reset        rising-edge clock, synchronous active-high reset
//     in_valid/pc/instr   fetch result
//     in_rs_id/rs_need    per-port source ids and per-port operand-needed flags
//     rf_data             register file read data, per port
//     in_wr_en/rd_id/wr_ready/wr_data  destination info of the incoming instr
//     fwd_id/ready/data   forwarding records of younger stages (index 0 youngest)
//     downstream_stall    next stage cannot accept
//     flush               squash the instruction being issued
//     out_*               issued instruction register
//     op_data             combinational forwarded operands (branch compare)
//     stall_out           holds fetch
//     self_id/ready/data  forwarding record of this stage
//     stall_count/stall_saturated  consecutive local-stall cycle counter
// -----------------------------------------------------------------------------
module decode_issue_stage #(
   parameter int XLEN   = 32,
   parameter int NPORTS = 2,
   parameter int NFWD   = 3,
   parameter int RID_W  = 5,
   parameter int CNT_W  = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [XLEN-1:0]         in_pc,
   input  logic [31:0]             in_instr,
   input  logic [NPORTS*RID_W-1:0] in_rs_id,
   input  logic [NPORTS-1:0]       in_rs_need,
   input  logic [NPORTS*XLEN-1:0]  rf_data,
   input  logic                    in_wr_en,
   input  logic [RID_W-1:0]        in_rd_id,
   input  logic                    in_wr_ready,
   input  logic [XLEN-1:0]         in_wr_data,
   input  logic [NFWD*RID_W-1:0]   fwd_id,
   input  logic [NFWD-1:0]         fwd_ready,
   input  logic [NFWD*XLEN-1:0]    fwd_data,
   input  logic                    downstream_stall,
   input  logic                    flush,
   output logic                    out_valid,
   output logic [XLEN-1:0]         out_pc,
   output logic [31:0]             out_instr,
   output logic [NPORTS*XLEN-1:0]  out_rs_data,
   output logic [RID_W-1:0]        out_rd_id,
   output logic                    out_wr_ready,
   output logic [XLEN-1:0]         out_wr_data,
   output logic [NPORTS*XLEN-1:0]  op_data,
   output logic                    stall_out,
   output logic [RID_W-1:0]        self_id,
   output logic                    self_ready,
   output logic [XLEN-1:0]         self_data,
   output logic [CNT_W-1:0]        stall_count,
   output logic                    stall_saturated
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NPORTS*XLEN-1:0] w_op_data;
   logic [NPORTS-1:0]      w_hazard;
   logic                   w_local_stall;
   logic                   w_load;

   logic                   r_valid;
   logic [XLEN-1:0]        r_pc;
   logic [31:0]            r_instr;
   logic [NPORTS*XLEN-1:0] r_rs_data;
   logic [RID_W-1:0]       r_rd_id;
   logic                   r_wr_ready;
   logic [XLEN-1:0]        r_wr_data;
   logic [CNT_W-1:0]       r_stall_count;

   // Operand selection: r0 reads as zero; otherwise the youngest matching
   // forwarding source wins, and a matching source that is not ready yet
   // is a hazard on that port.
   always_comb begin : operand_select
      logic v_found;
      w_op_data = '0;
      w_hazard  = '0;
      v_found   = 1'b0;
      for (int unsigned p = 0; p < NPORTS; p++) begin
         v_found = 1'b0;
         if (in_rs_id[p*RID_W +: RID_W] != '0) begin
            w_op_data[p*XLEN +: XLEN] = rf_data[p*XLEN +: XLEN];
            for (int unsigned i = 0; i < NFWD; i++) begin
               if (!v_found && (fwd_id[i*RID_W +: RID_W] == in_rs_id[p*RID_W +: RID_W])) begin
                  v_found = 1'b1;
                  if (fwd_ready[i])
                     w_op_data[p*XLEN +: XLEN] = fwd_data[i*XLEN +: XLEN];
                  else
                     w_hazard[p] = 1'b1;
               end
            end
         end
      end
   end

   assign w_local_stall = in_valid & (|(in_rs_need & w_hazard));
   assign w_load        = in_valid & ~w_local_stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid       <= 1'b0;
         r_rd_id       <= '0;
         r_wr_ready    <= 1'b1;
         r_wr_data     <= '0;
         r_stall_count <= '0;
      end else begin
         // The counter keeps running under downstream_stall; only flush or
         // a stall-free cycle clears it.
         if (flush || !w_local_stall)
            r_stall_count <= '0;
         else if (r_stall_count != CNT_MAX)
            r_stall_count <= r_stall_count + 1'b1;

         if (flush) begin
            r_valid <= 1'b0;
         end else if (!downstream_stall) begin
            r_valid <= w_load;
            if (w_load) begin
               r_pc       <= in_pc;
               r_instr    <= in_instr;
               r_rs_data  <= w_op_data;
               r_rd_id    <= in_wr_en ? in_rd_id    : '0;
               r_wr_ready <= in_wr_en ? in_wr_ready : 1'b1;
               r_wr_data  <= in_wr_en ? in_wr_data  : '0;
            end
         end
      end
   end

   assign out_valid       = r_valid;
   assign out_pc          = r_pc;
   assign out_instr       = r_instr;
   assign out_rs_data     = r_rs_data;
   assign out_rd_id       = r_rd_id;
   assign out_wr_ready    = r_wr_ready;
   assign out_wr_data     = r_wr_data;
   assign op_data         = w_op_data;
   assign stall_out       = w_local_stall | downstream_stall;
   assign self_id         = r_valid ? r_rd_id    : '0;
   assign self_ready      = r_valid ? r_wr_ready : 1'b1;
   assign self_data       = r_valid ? r_wr_data  : '0;
   assign stall_count     = r_stall_count;
   assign stall_saturated = (r_stall_count == CNT_MAX);

endmodule

// File: tb/tb_decode_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_stage
//   Directed stimulus with a scoreboard of expected issued instructions.
//   A second instance with CNT_W=2 shares all inputs to exercise saturation.
// -----------------------------------------------------------------------------
module tb_decode_issue_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic [9:0]  in_rs_id;
   logic [1:0]  in_rs_need;
   logic [63:0] rf_data;
   logic        in_wr_en;
   logic [4:0]  in_rd_id;
   logic        in_wr_ready;
   logic [31:0] in_wr_data;
   logic [14:0] fwd_id;
   logic [2:0]  fwd_ready;
   logic [95:0] fwd_data;
   logic        downstream_stall;
   logic        flush;

   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [63:0] out_rs_data;
   logic [4:0]  out_rd_id;
   logic        out_wr_ready;
   logic [31:0] out_wr_data;
   logic [63:0] op_data;
   logic        stall_out;
   logic [4:0]  self_id;
   logic        self_ready;
   logic [31:0] self_data;
   logic [7:0]  stall_count;
   logic        stall_saturated;

   logic        s_out_valid;
   logic [31:0] s_out_pc;
   logic [31:0] s_out_instr;
   logic [63:0] s_out_rs_data;
   logic [4:0]  s_out_rd_id;
   logic        s_out_wr_ready;
   logic [31:0] s_out_wr_data;
   logic [63:0] s_op_data;
   logic        s_stall_out;
   logic [4:0]  s_self_id;
   logic        s_self_ready;
   logic [31:0] s_self_data;
   logic [1:0]  s_stall_count;
   logic        s_stall_saturated;

   always #5 clock = ~clock;

   decode_issue_stage u_dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
      .in_instr(in_instr), .in_rs_id(in_rs_id), .in_rs_need(in_rs_need),
      .rf_data(rf_data), .in_wr_en(in_wr_en), .in_rd_id(in_rd_id),
      .in_wr_ready(in_wr_ready), .in_wr_data(in_wr_data), .fwd_id(fwd_id),
      .fwd_ready(fwd_ready), .fwd_data(fwd_data),
      .downstream_stall(downstream_stall), .flush(flush),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_rs_data(out_rs_data), .out_rd_id(out_rd_id),
      .out_wr_ready(out_wr_ready), .out_wr_data(out_wr_data),
      .op_data(op_data), .stall_out(stall_out), .self_id(self_id),
      .self_ready(self_ready), .self_data(self_data),
      .stall_count(stall_count), .stall_saturated(stall_saturated)
   );

   decode_issue_stage #(.CNT_W(2)) u_sat (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
      .in_instr(in_instr), .in_rs_id(in_rs_id), .in_rs_need(in_rs_need),
      .rf_data(rf_data), .in_wr_en(in_wr_en), .in_rd_id(in_rd_id),
      .in_wr_ready(in_wr_ready), .in_wr_data(in_wr_data), .fwd_id(fwd_id),
      .fwd_ready(fwd_ready), .fwd_data(fwd_data),
      .downstream_stall(downstream_stall), .flush(flush),
      .out_valid(s_out_valid), .out_pc(s_out_pc), .out_instr(s_out_instr),
      .out_rs_data(s_out_rs_data), .out_rd_id(s_out_rd_id),
      .out_wr_ready(s_out_wr_ready), .out_wr_data(s_out_wr_data),
      .op_data(s_op_data), .stall_out(s_stall_out), .self_id(s_self_id),
      .self_ready(s_self_ready), .self_data(s_self_data),
      .stall_count(s_stall_count), .stall_saturated(s_stall_saturated)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [63:0] rs;
      logic [4:0]  rd;
      logic        wr_ready;
      logic [31:0] wr_data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [63:0] rs,
                       input logic [4:0] rd, input logic wr_ready, input logic [31:0] wr_data);
      exp_t e;
      e.pc = pc; e.instr = instr; e.rs = rs; e.rd = rd; e.wr_ready = wr_ready; e.wr_data = wr_data;
      exp_q.push_back(e);
   endtask

   // One clock edge; pops and compares an issued instruction whenever the
   // edge was a load edge and the stage shows a valid output.
   task automatic step();
      logic l_hold;
      exp_t e;
      l_hold = downstream_stall | flush | reset;
      @(posedge clock);
      #1;
      if (!l_hold && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_issue", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc",       out_pc,       e.pc);
            chk("sb_instr",    out_instr,    e.instr);
            chk("sb_rs_data",  out_rs_data,  e.rs);
            chk("sb_rd_id",    out_rd_id,    e.rd);
            chk("sb_wr_ready", out_wr_ready, e.wr_ready);
            chk("sb_wr_data",  out_wr_data,  e.wr_data);
         end
      end
   endtask

   task automatic idle();
      in_valid = 0; in_pc = '0; in_instr = '0; in_rs_id = '0; in_rs_need = '0;
      rf_data = '0; in_wr_en = 0; in_rd_id = '0; in_wr_ready = 0; in_wr_data = '0;
      fwd_id = '0; fwd_ready = '0; fwd_data = '0; downstream_stall = 0; flush = 0;
   endtask

   // Hazard on port 0: r6 pending in youngest forwarding slot, not ready.
   task automatic hazard_inputs(input logic [31:0] pc);
      idle();
      in_valid = 1; in_pc = pc; in_instr = 32'h0000_6006;
      in_rs_id = {5'd0, 5'd6}; in_rs_need = 2'b01;
      fwd_id = {5'd0, 5'd0, 5'd6}; fwd_ready = 3'b000;
   endtask

   initial begin
      idle();
      reset = 1;
      step(); step();
      chk("rst_out_valid",  out_valid, 1'b0);
      chk("rst_out_rd_id",  out_rd_id, 5'd0);
      chk("rst_out_wr_rdy", out_wr_ready, 1'b1);
      chk("rst_out_wr_dat", out_wr_data, 32'd0);
      chk("rst_stall_cnt",  stall_count, 8'd0);
      chk("rst_self_ready", self_ready, 1'b1);
      reset = 0;

      // Plain register file read, no forwarding match.
      idle();
      in_valid = 1; in_pc = 32'h100; in_instr = 32'hDEAD_0001;
      in_rs_id = {5'd4, 5'd3}; in_rs_need = 2'b11;
      rf_data = {32'h22, 32'h11};
      in_wr_en = 1; in_rd_id = 5'd7; in_wr_ready = 1; in_wr_data = 32'h77;
      fwd_id = {5'd9, 5'd10, 5'd11}; fwd_ready = 3'b111;
      #1;
      chk("rf_op_data", op_data, {32'h22, 32'h11});
      chk("rf_stall_out", stall_out, 1'b0);
      push(32'h100, 32'hDEAD_0001, {32'h22, 32'h11}, 5'd7, 1'b1, 32'h77);
      step();
      chk("rf_out_valid", out_valid, 1'b1);
      chk("rf_self_id", self_id, 5'd7);
      chk("rf_self_data", self_data, 32'h77);

      // Youngest match wins; non-writing instruction clears rd record.
      idle();
      in_valid = 1; in_pc = 32'h104; in_instr = 32'hDEAD_0002;
      in_rs_id = {5'd9, 5'd3}; in_rs_need = 2'b11;
      rf_data = {32'h33, 32'h44};
      in_wr_en = 0; in_rd_id = 5'd9; in_wr_ready = 0; in_wr_data = 32'h99;
      fwd_id = {5'd3, 5'd9, 5'd3}; fwd_ready = 3'b111;
      fwd_data = {32'hB, 32'hC, 32'hA};
      #1;
      chk("fwd_op_data", op_data, {32'hC, 32'hA});
      push(32'h104, 32'hDEAD_0002, {32'hC, 32'hA}, 5'd0, 1'b1, 32'd0);
      step();
      chk("nowr_self_ready", self_ready, 1'b1);

      // r0 never forwards, even against a ready id-0 record.
      idle();
      in_valid = 1; in_pc = 32'h108; in_instr = 32'hDEAD_0003;
      in_rs_id = {5'd0, 5'd0}; in_rs_need = 2'b11;
      rf_data = {32'h55, 32'h66};
      fwd_id = {5'd0, 5'd0, 5'd0}; fwd_ready = 3'b001; fwd_data = {32'h0, 32'h0, 32'hFF};
      #1;
      chk("r0_op_data", op_data, 64'd0);
      chk("r0_stall_out", stall_out, 1'b0);
      push(32'h108, 32'hDEAD_0003, 64'd0, 5'd0, 1'b1, 32'd0);
      step();

      // Not-ready match on port 0 stalls; resolves when it becomes ready.
      idle();
      in_valid = 1; in_pc = 32'h10C; in_instr = 32'hDEAD_0004;
      in_rs_id = {5'd0, 5'd5}; in_rs_need = 2'b01;
      rf_data = {32'h0, 32'h12};
      fwd_id = {5'd0, 5'd5, 5'd2}; fwd_ready = 3'b001;
      #1;
      chk("haz_stall_out", stall_out, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("haz_out_valid", out_valid, 1'b0);
         chk("haz_stall_cnt", stall_count, 8'(k));
      end
      fwd_ready = 3'b011; fwd_data = {32'h0, 32'h55, 32'h0};
      #1;
      chk("haz_res_stall_out", stall_out, 1'b0);
      push(32'h10C, 32'hDEAD_0004, {32'h0, 32'h55}, 5'd0, 1'b1, 32'd0);
      step();
      chk("haz_res_valid", out_valid, 1'b1);
      chk("haz_res_cnt", stall_count, 8'd0);

      // Hazard on an operand not needed here is ignored.
      fwd_ready = 3'b001; in_pc = 32'h110; in_rs_need = 2'b10;
      #1;
      chk("noneed_stall_out", stall_out, 1'b0);
      push(32'h110, 32'hDEAD_0004, {32'h0, 32'h12}, 5'd0, 1'b1, 32'd0);
      step();

      // Saturation on the narrow counter.
      hazard_inputs(32'h200);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("sat_cnt2", s_stall_count, (k < 3) ? 2'(k) : 2'd3);
         chk("sat_flag2", s_stall_saturated, (k >= 3));
         chk("sat_cnt8", stall_count, 8'(k));
         chk("sat_flag8", stall_saturated, 1'b0);
      end
      idle();
      step();
      chk("sat_clear", s_stall_count, 2'd0);
      chk("bubble_valid", out_valid, 1'b0);

      // Downstream stall holds everything.
      idle();
      in_valid = 1; in_pc = 32'h300; in_instr = 32'hDEAD_0300;
      in_rs_id = {5'd1, 5'd2}; rf_data = {32'hA1, 32'hA2};
      in_wr_en = 1; in_rd_id = 5'd12; in_wr_ready = 0; in_wr_data = 32'hC0DE;
      push(32'h300, 32'hDEAD_0300, {32'hA1, 32'hA2}, 5'd12, 1'b0, 32'hC0DE);
      step();
      in_pc = 32'h400; in_instr = 32'hDEAD_0400; rf_data = {32'hB1, 32'hB2};
      in_rd_id = 5'd13; in_wr_ready = 1; in_wr_data = 32'hBEEF;
      downstream_stall = 1;
      #1;
      chk("ds_stall_out", stall_out, 1'b1);
      step();
      chk("ds_hold_valid", out_valid, 1'b1);
      chk("ds_hold_pc", out_pc, 32'h300);
      chk("ds_hold_instr", out_instr, 32'hDEAD_0300);
      chk("ds_hold_rs", out_rs_data, {32'hA1, 32'hA2});
      chk("ds_hold_self_id", self_id, 5'd12);
      chk("ds_hold_self_rdy", self_ready, 1'b0);
      downstream_stall = 0;
      push(32'h400, 32'hDEAD_0400, {32'hB1, 32'hB2}, 5'd13, 1'b1, 32'hBEEF);
      step();

      // Hazard under downstream stall: hold while counting.
      hazard_inputs(32'h500);
      downstream_stall = 1;
      step();
      chk("dsh_cnt", stall_count, 8'd1);
      chk("dsh_hold_pc", out_pc, 32'h400);
      chk("dsh_hold_valid", out_valid, 1'b1);

      // Flush wins over downstream stall and clears the counter.
      flush = 1;
      step();
      chk("fl_valid", out_valid, 1'b0);
      chk("fl_cnt", stall_count, 8'd0);
      chk("fl_self_id", self_id, 5'd0);
      idle();
      flush = 1;
      #1;
      chk("fl_alone_stall_out", stall_out, 1'b0);
      step();

      // Reset mid-stall discards the held instruction.
      idle();
      in_valid = 1; in_pc = 32'h600; in_instr = 32'hDEAD_0600;
      in_wr_en = 1; in_rd_id = 5'd20; in_wr_ready = 1; in_wr_data = 32'h600;
      push(32'h600, 32'hDEAD_0600, 64'd0, 5'd20, 1'b1, 32'h600);
      step();
      hazard_inputs(32'h700);
      downstream_stall = 1;
      step();
      chk("rms_cnt_pre", stall_count, 8'd1);
      reset = 1;
      step();
      chk("rms_valid", out_valid, 1'b0);
      chk("rms_cnt", stall_count, 8'd0);
      chk("rms_rd_id", out_rd_id, 5'd0);
      chk("rms_wr_data", out_wr_data, 32'd0);
      reset = 0;
      idle();
      step();

      chk("sb_leftover", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=1 exp=0");
      $fatal(1);
   end

endmodule
